// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode encodings, register file geometry and
// the writeback FSM state type.
package pipe_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 4;
    localparam int OP_W     = 4;
    localparam int IDX_W    = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OP_W-1:0] OP_WR_LO = 4'h1;
    localparam logic [OP_W-1:0] OP_WR_HI = 4'h7;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_t;

    function automatic logic is_wr_op(input logic [OP_W-1:0] op);
        return (op >= OP_WR_LO) && (op <= OP_WR_HI);
    endfunction

endpackage

// File: rtl/regfile_4x16.sv
// Four-entry, 16-bit register file: one synchronous write port, two
// combinational read ports, asynchronous active-low clear.
module regfile_4x16
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr1,
    input  logic [1:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic [DATA_W-1:0] q3
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign q0     = mem[0];
    assign q1     = mem[1];
    assign q2     = mem[2];
    assign q3     = mem[3];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: WB pipeline register, bypassed register reads, retire
// counter, bad-index flag and the RUN/HALTED control FSM.
//
//   state     | meaning
//   ST_RUN    | normal retirement: writes commit, bypass active, count advances
//   ST_HALTED | HALT retired; writes, bypass and count frozen until reset
module wb_regfile
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_opcode,
    input  logic [IDX_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [IDX_W-1:0]  rd_addr1,
    input  logic [IDX_W-1:0]  rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic              halted,
    output logic              bad_rd,
    output logic [DATA_W-1:0] retired
);

    logic              wb_valid;
    logic [OP_W-1:0]   wb_op;
    logic [IDX_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    wb_state_t state, state_nxt;

    logic              in_run;
    logic              wr_req;
    logic              wr_commit;
    logic              wr_bad;
    logic              retire;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    // The WB register keeps capturing even when halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_op    <= OP_NOP;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= ex_valid;
            wb_op    <= ex_opcode;
            wb_rd    <= ex_rd;
            wb_data  <= ex_result;
        end
    end

    assign in_run    = (state == ST_RUN);
    assign wr_req    = wb_valid && is_wr_op(wb_op) && in_run;
    assign wr_commit = wr_req && (wb_rd < IDX_W'(NUM_REGS));
    assign wr_bad    = wr_req && (wb_rd >= IDX_W'(NUM_REGS));
    assign retire    = wb_valid && in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (wb_valid && (wb_op == OP_HALT)) state_nxt = ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    assign halted = (state == ST_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
            bad_rd  <= 1'b0;
        end else begin
            if (retire && (retired != {DATA_W{1'b1}})) begin
                retired <= retired + 1'b1;
            end
            if (wr_bad) begin
                bad_rd <= 1'b1;
            end
        end
    end

    regfile_4x16 u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_commit),
        .waddr  (wb_rd[1:0]),
        .wdata  (wb_data),
        .raddr1 (rd_addr1[1:0]),
        .raddr2 (rd_addr2[1:0]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .q0     (R0),
        .q1     (R1),
        .q2     (R2),
        .q3     (R3)
    );

    // wr_commit already implies wb_rd is in range, so a bypass never aliases
    // an out-of-range read index onto a real register.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (wr_commit && (rd_addr1 == wb_rd)) begin
            rd_data1 = wb_data;
        end else if (rd_addr1 < IDX_W'(NUM_REGS)) begin
            rd_data1 = rf_rdata1;
        end
        if (wr_commit && (rd_addr2 == wb_rd)) begin
            rd_data2 = wb_data;
        end else if (rd_addr2 < IDX_W'(NUM_REGS)) begin
            rd_data2 = rf_rdata2;
        end
    end

endmodule
